// File: rtl/accel_decimal_printer_pkg.sv
// Shared definitions for the decimal printer: FSM encoding, character codes
// and the minimum-digit helper used to reject undersized DIGITS settings.
// No logic; constants and a constant function only.
package accel_decimal_printer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_CONVERT    = 3'd1,
    ST_EMIT_SIGN  = 3'd2,
    ST_EMIT_DIGIT = 3'd3,
    ST_EMIT_TERM  = 3'd4
  } state_t;

  localparam logic [7:0] CHAR_ZERO  = 8'h30;
  localparam logic [7:0] CHAR_MINUS = 8'h2D;
  localparam logic [7:0] RAW_MINUS  = 8'd11;

  // ceil(width * log10(2)) in integer arithmetic (log10(2) ~= 0.30103).
  function automatic int min_digits(input int width);
    return (width * 30103 + 99999) / 100000;
  endfunction

endpackage

// File: rtl/accel_decimal_printer_bin2bcd_seq.sv
// Sequential double-dabble: binary to packed BCD, one input bit per cycle.
// Latency: start loads and consumes the first bit; done pulses DATA_W cycles later (bcd then final and held).
// Backpressure: none; the caller only pulses start when it is ready for a new conversion.
//
// Ports: clk, rst (async active-high), start (load bin), bin (unsigned value),
//        done (one-cycle pulse, bcd valid), bcd (4*DIGITS bits, digit 0 in bits [3:0]).
module bin2bcd_seq #(
  parameter int DATA_W = 18,
  parameter int DIGITS = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_W-1:0]     bin,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int CW = $clog2(DATA_W + 1);

  logic [DATA_W-1:0]   shreg;
  logic [CW-1:0]       remaining;
  logic [4*DIGITS-1:0] bcd_adj;

  // Add-3 correction on every digit that would overflow past 9 when doubled.
  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shreg     <= '0;
      bcd       <= '0;
      remaining <= '0;
      done      <= 1'b0;
    end else if (start) begin
      // With an all-zero BCD the first step is a plain shift, so it is folded into the load.
      bcd       <= {{(4*DIGITS-1){1'b0}}, bin[DATA_W-1]};
      shreg     <= bin << 1;
      remaining <= CW'(DATA_W - 1);
      done      <= (DATA_W == 1);
    end else if (remaining != '0) begin
      bcd       <= {bcd_adj[4*DIGITS-2:0], shreg[DATA_W-1]};
      shreg     <= shreg << 1;
      remaining <= remaining - 1'b1;
      done      <= (remaining == CW'(1));
    end else begin
      done      <= 1'b0;
    end
  end

endmodule

// File: rtl/accel_decimal_printer.sv
// Converts one binary accelerator result to decimal and streams it as characters: [sign] digits terminator.
// Latency: first character valid DATA_W+1 cycles after the input handshake, then one char per cycle.
// Backpressure: ready/valid on both sides; out_char/out_valid are registered and held while out_ready is low.
//
// Ports: clk, rst (async active-high); in_data/in_valid/in_ready (result input, ready only when idle);
//        out_char/out_valid/out_ready (character stream); busy (high whenever not idle).
module accel_decimal_printer
  import accel_decimal_printer_pkg::*;
#(
  parameter int         DATA_W      = 18,
  parameter int         DIGITS      = 6,
  parameter int         SIGNED      = 0,
  parameter int         SUPPRESS_LZ = 1,
  parameter int         ASCII       = 1,
  parameter logic [7:0] TERM_CHAR   = 8'd10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [7:0]        out_char,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  localparam int         IW        = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [7:0] SIGN_CHAR = (ASCII != 0) ? CHAR_MINUS : RAW_MINUS;

  if (DIGITS < min_digits(DATA_W)) begin : g_digits_check
    $error("accel_decimal_printer: DIGITS too small to hold DATA_W bits");
  end

  state_t              state;
  logic                neg;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       lz_idx;
  logic [DATA_W-1:0]   mag;
  logic                in_hs;
  logic                out_hs;
  logic                conv_done;
  logic [4*DIGITS-1:0] bcd;

  assign in_hs  = in_valid & in_ready;
  assign out_hs = out_valid & out_ready;

  // Magnitude fits DATA_W unsigned bits, so the most negative input converts exactly.
  always_comb begin
    mag = in_data;
    if (SIGNED != 0 && in_data[DATA_W-1]) mag = -in_data;
  end

  bin2bcd_seq #(
    .DATA_W (DATA_W),
    .DIGITS (DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .rst   (rst),
    .start (in_hs),
    .bin   (mag),
    .done  (conv_done),
    .bcd   (bcd)
  );

  // Start index: highest nonzero digit (0 for value 0), or the full width when zeros are kept.
  always_comb begin
    lz_idx = '0;
    if (SUPPRESS_LZ != 0) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (bcd[4*i +: 4] != 4'd0) lz_idx = IW'(i);
      end
    end else begin
      lz_idx = IW'(DIGITS - 1);
    end
  end

  function automatic logic [3:0] sel_digit(input logic [4*DIGITS-1:0] v, input logic [IW-1:0] i);
    logic [3:0] r;
    r = '0;
    for (int k = 0; k < DIGITS; k++) begin
      if (IW'(k) == i) r = v[4*k +: 4];
    end
    return r;
  endfunction

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    if (ASCII != 0) return CHAR_ZERO + {4'b0000, d};
    return {4'b0000, d};
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      neg       <= 1'b0;
      idx       <= '0;
      out_char  <= '0;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_hs) begin
            neg      <= (SIGNED != 0) && in_data[DATA_W-1];
            state    <= ST_CONVERT;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        ST_CONVERT: begin
          if (conv_done) begin
            idx       <= lz_idx;
            out_valid <= 1'b1;
            if (neg) begin
              state    <= ST_EMIT_SIGN;
              out_char <= SIGN_CHAR;
            end else begin
              state    <= ST_EMIT_DIGIT;
              out_char <= digit_char(sel_digit(bcd, lz_idx));
            end
          end
        end
        ST_EMIT_SIGN: begin
          if (out_hs) begin
            state    <= ST_EMIT_DIGIT;
            out_char <= digit_char(sel_digit(bcd, idx));
          end
        end
        ST_EMIT_DIGIT: begin
          if (out_hs) begin
            if (idx == '0) begin
              state    <= ST_EMIT_TERM;
              out_char <= TERM_CHAR;
            end else begin
              idx      <= idx - 1'b1;
              out_char <= digit_char(sel_digit(bcd, idx - 1'b1));
            end
          end
        end
        ST_EMIT_TERM: begin
          if (out_hs) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            out_char  <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= ST_IDLE;
          out_valid <= 1'b0;
          out_char  <= '0;
          in_ready  <= 1'b1;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_accel_decimal_printer.sv
// Bench for accel_decimal_printer: four parameter variants driven by directed and random words,
// expected character streams computed arithmetically from the value and the variant's options.
// Checks characters, first-char latency, bubble-free streaming, stall stability, reset behaviour.
module tb_accel_decimal_printer;

  localparam int DW = 18;
  localparam int NI = 4;
  // Per-instance options, bit g for instance g.
  //   inst0: unsigned, suppress, ascii   inst1: signed, suppress, ascii
  //   inst2: signed, keep zeros, raw     inst3: unsigned, keep zeros, ascii
  localparam bit [NI-1:0] P_SIGNED = 4'b0110;
  localparam bit [NI-1:0] P_LZ     = 4'b0011;
  localparam bit [NI-1:0] P_ASCII  = 4'b1011;

  logic          clk = 1'b0;
  logic          rst       [NI];
  logic [DW-1:0] in_data   [NI];
  logic          in_valid  [NI];
  logic          in_ready  [NI];
  logic [7:0]    out_char  [NI];
  logic          out_valid [NI];
  logic          out_ready [NI];
  logic          busy      [NI];

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    accel_decimal_printer #(
      .DATA_W      (DW),
      .DIGITS      (6),
      .SIGNED      (int'(P_SIGNED[g])),
      .SUPPRESS_LZ (int'(P_LZ[g])),
      .ASCII       (int'(P_ASCII[g])),
      .TERM_CHAR   (8'd10)
    ) u_dut (
      .clk       (clk),
      .rst       (rst[g]),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .out_char  (out_char[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .busy      (busy[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic pick(input int pct);
    if (pct >= 100) return 1'b1;
    return int'($urandom_range(99)) < pct;
  endfunction

  // Reference: print the value in decimal by repeated division, per the variant's options.
  task automatic build_exp(input int n, input logic [DW-1:0] d);
    int  v;
    int  p;
    int  st;
    int  dig[6];
    bit  ng;
    ng = P_SIGNED[n] && d[DW-1];
    v  = ng ? ((1 << DW) - int'(d)) : int'(d);
    p  = 1;
    for (int i = 0; i < 6; i++) begin
      dig[i] = (v / p) % 10;
      p = p * 10;
    end
    st = 5;
    if (P_LZ[n]) begin
      st = 0;
      for (int i = 0; i < 6; i++) if (dig[i] != 0) st = i;
    end
    if (ng) exp_q.push_back(P_ASCII[n] ? 8'h2D : 8'd11);
    for (int i = st; i >= 0; i--) exp_q.push_back(P_ASCII[n] ? 8'(48 + dig[i]) : 8'(dig[i]));
    exp_q.push_back(8'h0A);
  endtask

  // Send d (and optionally d2, held valid while busy) on instance n and check the stream.
  // Entered and left at posedge+1.
  task automatic run(input int n, input logic [DW-1:0] d, input int pct,
                     input bit two, input logic [DW-1:0] d2);
    int n1, c, acc, c_acc0, c_acc1, first_v, term1_c, nv;
    bit stall;
    logic [7:0] pchar;
    logic [31:0] obs;
    exp_q.delete();
    got_q.delete();
    build_exp(n, d);
    n1 = exp_q.size();
    if (two) build_exp(n, d2);
    acc = 0; c = 0; c_acc0 = -1; c_acc1 = -1; first_v = -1; term1_c = -1;
    stall = 1'b0; pchar = '0;
    in_data[n]   = d;
    in_valid[n]  = 1'b1;
    out_ready[n] = pick(pct);
    while (got_q.size() < exp_q.size() && c < 3000) begin
      @(negedge clk);
      c++;
      if (in_valid[n] && in_ready[n]) begin
        if (acc == 0) c_acc0 = c; else c_acc1 = c;
        acc++;
      end
      if (stall) begin
        check("stall_valid", 32'(out_valid[n]), 32'd1);
        check("stall_char", 32'(out_char[n]), 32'(pchar));
      end
      if (out_valid[n] && first_v < 0) begin
        first_v = c;
        check("busy_while_emit", 32'(busy[n]), 32'd1);
        check("in_ready_while_emit", 32'(in_ready[n]), 32'd0);
      end
      if (out_valid[n] && out_ready[n]) begin
        got_q.push_back(out_char[n]);
        if (got_q.size() == n1) term1_c = c;
      end
      stall = out_valid[n] && !out_ready[n];
      pchar = out_char[n];
      @(posedge clk);
      #1;
      if (acc >= (two ? 2 : 1)) in_valid[n] = 1'b0;
      else if (acc == 1) in_data[n] = d2;
      out_ready[n] = pick(pct);
    end
    in_valid[n]  = 1'b0;
    out_ready[n] = 1'b1;
    check("char_count", 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      obs = (i < got_q.size()) ? 32'(got_q[i]) : 32'hFFFF_FFFF;
      check("char", obs, 32'(exp_q[i]));
    end
    check("accept_count", 32'(acc), two ? 32'd2 : 32'd1);
    check("first_valid_latency", 32'(first_v - c_acc0), 32'(DW + 1));
    if (two) check("second_accept_after_term", 32'(c_acc1), 32'(term1_c + 1));
    if (pct >= 100 && !two) check("no_bubbles", 32'(term1_c - first_v + 1), 32'(n1));
    @(negedge clk);
    check("in_ready_after_term", 32'(in_ready[n]), 32'd1);
    check("busy_after_term", 32'(busy[n]), 32'd0);
    nv = 0;
    for (int i = 0; i < 4; i++) begin
      if (out_valid[n]) nv++;
      @(negedge clk);
    end
    check("no_extra_chars", 32'(nv), 32'd0);
    @(posedge clk);
    #1;
  endtask

  // Assert rst on instance 0 now (mid-cycle) and check the outputs drop before any clock edge.
  task automatic async_reset_check(input string tag);
    int nv;
    rst[0] = 1'b1;
    #1;
    check({tag, "_out_valid"}, 32'(out_valid[0]), 32'd0);
    check({tag, "_out_char"}, 32'(out_char[0]), 32'd0);
    check({tag, "_in_ready"}, 32'(in_ready[0]), 32'd1);
    check({tag, "_busy"}, 32'(busy[0]), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst[0] = 1'b0;
    nv = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (out_valid[0]) nv++;
    end
    check({tag, "_silent_after"}, 32'(nv), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int n;
    int pct;
    logic [DW-1:0] d;

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; in_data[i] = '0; in_valid[i] = 1'b0; out_ready[i] = 1'b1;
    end
    #2;
    for (int i = 0; i < NI; i++) begin
      check("reset_out_valid", 32'(out_valid[i]), 32'd0);
      check("reset_in_ready", 32'(in_ready[i]), 32'd1);
    end
    check("reset_out_char", 32'(out_char[0]), 32'd0);
    check("reset_busy", 32'(busy[0]), 32'd0);
    @(posedge clk);
    #1;
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    @(posedge clk);
    #1;

    // Zeros kept, ASCII: "001234\n".
    run(3, 18'd1234, 100, 1'b0, '0);
    // Leading-zero suppression: zero and full-scale.
    run(0, 18'd0, 100, 1'b0, '0);
    run(0, 18'd262143, 100, 1'b0, '0);
    // Signed: most negative and -1.
    run(1, 18'h20000, 100, 1'b0, '0);
    run(1, 18'h3FFFF, 100, 1'b0, '0);
    // Raw encoding, zeros kept, positive and negative.
    run(2, 18'd1234, 100, 1'b0, '0);
    run(2, 18'h3FFFB, 100, 1'b0, '0);
    // Backpressure at 30% ready, second word held valid while busy.
    run(0, 18'd987, 30, 1'b1, 18'd555);

    // Reset after three characters of 123456.
    got_q.delete();
    in_data[0] = 18'd123456; in_valid[0] = 1'b1; out_ready[0] = 1'b1;
    c = 0;
    while (got_q.size() < 3 && c < 200) begin
      @(negedge clk);
      c++;
      if (out_valid[0] && out_ready[0]) got_q.push_back(out_char[0]);
      @(posedge clk);
      #1;
      if (busy[0]) in_valid[0] = 1'b0;
    end
    in_valid[0] = 1'b0;
    check("pre_reset_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("pre_reset_c0", 32'(got_q[0]), 32'h31);
      check("pre_reset_c1", 32'(got_q[1]), 32'h32);
      check("pre_reset_c2", 32'(got_q[2]), 32'h33);
    end
    #2;
    async_reset_check("rst_emit");
    run(0, 18'd42, 100, 1'b0, '0);

    // Reset in the middle of the conversion.
    in_data[0] = 18'd123456; in_valid[0] = 1'b1;
    c = 0;
    while (!busy[0] && c < 10) begin
      @(posedge clk);
      #1;
      c++;
    end
    in_valid[0] = 1'b0;
    check("convert_accept", 32'(busy[0]), 32'd1);
    repeat (5) @(posedge clk);
    #3;
    async_reset_check("rst_convert");
    run(0, 18'd42, 100, 1'b0, '0);

    // Random words across all variants and ready patterns.
    for (int k = 0; k < 16; k++) begin
      n   = int'($urandom_range(NI - 1));
      d   = DW'($urandom);
      pct = ($urandom_range(1) == 1) ? 100 : int'($urandom_range(90, 20));
      run(n, d, pct, 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
